// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: PID codes, SYNC/CRC constants, receive states and the serial CRC16 step.
package usb_rx_pkg;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [6:0] PID_LAST = 7'd7;
  localparam logic [6:0] DATA_LAST = 7'd63;
  localparam logic [6:0] CRC_LAST = 7'd15;
  typedef enum logic [2:0] {HUNT, PID, HS_EOP, DATA, CRC, D_EOP, ERR} rx_state_t;
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0);
  endfunction
endpackage

// File: rtl/rx_packet_decoder_if.sv
// rx_packet_decoder_if: bit stream from the line decoder and decoded results to the protocol handler.
interface rx_packet_decoder_if;
  logic bit_in, bit_valid, eop;
  logic ACK_rec, NAK_rec, DATA0_rec, crc_sending, crc_done, crc_valid, pid_error;
  logic [63:0] data0;
  modport master (
    output bit_in, bit_valid, eop,
    input ACK_rec, NAK_rec, DATA0_rec, crc_sending, crc_done, crc_valid, pid_error, data0
  );
  modport slave (
    input bit_in, bit_valid, eop,
    output ACK_rec, NAK_rec, DATA0_rec, crc_sending, crc_done, crc_valid, pid_error, data0
  );
endinterface

// File: rtl/usb_crc16_serial.sv
// usb_crc16_serial: bit-serial USB CRC16, shared by the receive and transmit paths.
module usb_crc16_serial
  import usb_rx_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic [15:0] crc
);
  always_ff @(posedge clock)
    if (!reset_n || clear) crc <= CRC16_INIT;
    else if (bit_valid) crc <= crc16_step(crc, bit_in);
endmodule

// File: rtl/rx_packet_decoder.sv
// rx_packet_decoder: hunts SYNC, checks the PID, collects a 64-bit DATA0 payload and verifies its CRC16.
module rx_packet_decoder
  import usb_rx_pkg::*;
(
  input logic clock,
  input logic reset_n,
  rx_packet_decoder_if.slave rx
);
  rx_state_t state, state_n;
  logic [6:0] win, win_n, cnt, cnt_n;
  logic [7:0] pid, pid_n;
  logic [62:0] shadow;
  logic [15:0] crc;
  logic bv, ack_n, nak_n, d0_n, done_n, perr_n;
  assign bv = rx.bit_valid & ~rx.eop;
  usb_crc16_serial u_crc (
    .clock(clock),
    .reset_n(reset_n),
    .clear(d0_n),
    .bit_valid(bv && (state == DATA || state == CRC)),
    .bit_in(rx.bit_in),
    .crc(crc)
  );
  always_comb begin
    state_n = state;
    win_n = (state == HUNT && !rx.eop) ? (bv ? {rx.bit_in, win[6:1]} : win) : 7'h0;
    pid_n = (state == PID && bv) ? {rx.bit_in, pid[7:1]} : pid;
    ack_n = 1'b0;
    nak_n = 1'b0;
    d0_n = 1'b0;
    done_n = 1'b0;
    perr_n = 1'b0;
    case (state)
      HUNT: if (bv && {rx.bit_in, win} == SYNC_PATTERN) state_n = PID;
      PID:
        if (rx.eop) begin
          state_n = HUNT;
          perr_n = 1'b1;
        end else if (bv && cnt == PID_LAST) begin
          if (pid_n[7:4] != ~pid_n[3:0]) state_n = ERR;
          else if (pid_n[3:0] == PID_ACK || pid_n[3:0] == PID_NAK) state_n = HS_EOP;
          else if (pid_n[3:0] == PID_DATA0) begin
            state_n = DATA;
            d0_n = 1'b1;
          end else state_n = ERR;
        end
      HS_EOP:
        if (rx.eop) begin
          state_n = HUNT;
          ack_n = pid[3:0] == PID_ACK;
          nak_n = pid[3:0] == PID_NAK;
        end else if (bv) state_n = ERR;
      DATA, CRC:
        if (rx.eop) begin
          state_n = HUNT;
          perr_n = 1'b1;
        end else if (bv && cnt == (state == DATA ? DATA_LAST : CRC_LAST))
          state_n = state == DATA ? CRC : D_EOP;
      D_EOP:
        if (rx.eop) begin
          state_n = HUNT;
          done_n = 1'b1;
        end else if (bv) state_n = ERR;
      ERR: if (rx.eop) state_n = HUNT;
      default: state_n = HUNT;
    endcase
    if (state_n == ERR && state != ERR) perr_n = 1'b1;
    cnt_n = state_n != state ? 7'd0 : (bv && (state == PID || state == DATA || state == CRC)) ? cnt + 7'd1 : cnt;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= HUNT;
      win <= '0;
      cnt <= '0;
      pid <= '0;
      shadow <= '0;
      rx.ACK_rec <= 1'b0;
      rx.NAK_rec <= 1'b0;
      rx.DATA0_rec <= 1'b0;
      rx.crc_sending <= 1'b0;
      rx.crc_done <= 1'b0;
      rx.crc_valid <= 1'b0;
      rx.pid_error <= 1'b0;
      rx.data0 <= '0;
    end else begin
      state <= state_n;
      win <= win_n;
      cnt <= cnt_n;
      pid <= pid_n;
      rx.ACK_rec <= ack_n;
      rx.NAK_rec <= nak_n;
      rx.DATA0_rec <= d0_n;
      rx.crc_sending <= state_n == CRC;
      rx.crc_done <= done_n;
      rx.crc_valid <= done_n && crc == CRC16_RESIDUAL;
      rx.pid_error <= perr_n;
      if (state == DATA && bv) shadow <= {rx.bit_in, shadow[62:1]};
      if (state == DATA && bv && cnt == DATA_LAST) rx.data0 <= {rx.bit_in, shadow};
    end
  end
endmodule

// File: tb/tb_rx_packet_decoder.sv
// tb_rx_packet_decoder: scoreboard bench; expected pulses are queued as stimulus is driven and matched against observed pulses.
module tb_rx_packet_decoder;
  typedef struct packed {
    logic [2:0] kind;
    logic valid;
    logic [7:0] cs;
    logic [63:0] data;
    logic [31:0] cyc;
  } ev_t;
  localparam logic [2:0] K_ACK = 3'd1, K_NAK = 3'd2, K_D0 = 3'd3, K_DONE = 3'd4, K_PERR = 3'd5, K_STRAY = 3'd6;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] cyc = '0;
  logic [7:0] cs_cnt = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int rd = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];
  rx_packet_decoder_if rx();
  rx_packet_decoder dut (.clock(clock), .reset_n(reset_n), .rx(rx));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 32'd1;
  function automatic ev_t mk(input logic [2:0] k, input logic v, input logic [7:0] c, input logic [63:0] d, input logic [31:0] t);
    ev_t e;
    e.kind = k;
    e.valid = v;
    e.cs = c;
    e.data = d;
    e.cyc = t;
    return e;
  endfunction
  // Observed pulses are logged with the cycle they appear in; crc_sending is measured in valid bits.
  always @(negedge clock) begin
    if (rx.ACK_rec === 1'b1) obs_q.push_back(mk(K_ACK, 1'b0, 8'd0, 64'd0, cyc));
    if (rx.NAK_rec === 1'b1) obs_q.push_back(mk(K_NAK, 1'b0, 8'd0, 64'd0, cyc));
    if (rx.DATA0_rec === 1'b1) begin
      obs_q.push_back(mk(K_D0, 1'b0, 8'd0, 64'd0, cyc));
      cs_cnt = '0;
    end
    if (rx.crc_sending === 1'b1 && rx.bit_valid === 1'b1 && rx.eop === 1'b0) cs_cnt = cs_cnt + 8'd1;
    if (rx.crc_done === 1'b1) obs_q.push_back(mk(K_DONE, rx.crc_valid, cs_cnt, rx.data0, cyc));
    if (rx.pid_error === 1'b1) obs_q.push_back(mk(K_PERR, 1'b0, 8'd0, 64'd0, cyc));
    if (rx.crc_valid === 1'b1 && rx.crc_done !== 1'b1) obs_q.push_back(mk(K_STRAY, 1'b1, 8'd0, 64'd0, cyc));
  end
  task automatic drive(input logic v, input logic b, input logic e);
    @(posedge clock);
    #1;
    rx.bit_valid = v;
    rx.bit_in = b;
    rx.eop = e;
  endtask
  task automatic send_bits(input logic [63:0] bits, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, bits[i], 1'b0);
    end
  endtask
  function automatic logic [15:0] ref_crc(input logic [63:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 64; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h8005 : 16'h0);
    return c;
  endfunction
  task automatic send_handshake(input logic [7:0] p, input logic [2:0] k, input bit gaps);
    send_bits(64'h80, 8, gaps);
    send_bits({56'd0, p}, 8, gaps);
    if (gaps) repeat (3) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk(k, 1'b0, 8'd0, 64'd0, cyc + 32'd1));
    drive(1'b0, 1'b0, 1'b0);
  endtask
  task automatic send_data(input logic [63:0] d, input bit flip);
    logic [15:0] tx;
    logic [63:0] cb;
    send_bits(64'h80, 8, 1'b0);
    send_bits(64'hC3, 8, 1'b0);
    exp_q.push_back(mk(K_D0, 1'b0, 8'd0, 64'd0, cyc + 32'd1));
    send_bits(d, 64, 1'b0);
    tx = ~ref_crc(d);
    cb = '0;
    for (int i = 0; i < 16; i++) cb[i] = tx[15-i];
    cb[5] = cb[5] ^ flip;
    send_bits(cb, 16, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk(K_DONE, !flip, 8'd16, d, cyc + 32'd1));
    drive(1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset;
    rx.bit_valid = 1'b0;
    rx.bit_in = 1'b0;
    rx.eop = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({rx.ACK_rec, rx.NAK_rec, rx.DATA0_rec, rx.crc_sending, rx.crc_done, rx.crc_valid, rx.pid_error} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 0000000", {rx.ACK_rec, rx.NAK_rec, rx.DATA0_rec, rx.crc_sending, rx.crc_done, rx.crc_valid, rx.pid_error});
    end
    n_cmp++;
    if (rx.data0 !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_data0: got %h expected 0", rx.data0);
    end
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rd = obs_q.size();
  endtask
  task automatic test_handshakes;
    ev_t e, o;
    send_handshake(8'hD2, K_ACK, 1'b0);
    send_handshake(8'h5A, K_NAK, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd >= obs_q.size()) begin
        n_bad++;
        $display("FAIL handshake: no event, expected %p", e);
      end else begin
        o = obs_q[rd];
        rd++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL handshake: got %p expected %p", o, e);
        end
      end
    end
    n_cmp++;
    if (rd != obs_q.size()) begin
      n_bad++;
      $display("FAIL handshake_extra: got %0d unexpected events expected 0", obs_q.size() - rd);
      rd = obs_q.size();
    end
  endtask
  task automatic test_data;
    ev_t e, o;
    send_data(64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    send_data(64'hDEAD_BEEF_0BAD_F00D, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd >= obs_q.size()) begin
        n_bad++;
        $display("FAIL data: no event, expected %p", e);
      end else begin
        o = obs_q[rd];
        rd++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL data: got %p expected %p", o, e);
        end
      end
    end
    n_cmp++;
    if (rd != obs_q.size()) begin
      n_bad++;
      $display("FAIL data_extra: got %0d unexpected events expected 0", obs_q.size() - rd);
      rd = obs_q.size();
    end
  endtask
  task automatic test_bad_pid;
    ev_t e, o;
    send_bits(64'h80, 8, 1'b0);
    send_bits(64'hD3, 8, 1'b0);
    exp_q.push_back(mk(K_PERR, 1'b0, 8'd0, 64'd0, cyc + 32'd1));
    send_bits({$urandom, $urandom}, 20, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    send_handshake(8'hD2, K_ACK, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd >= obs_q.size()) begin
        n_bad++;
        $display("FAIL bad_pid: no event, expected %p", e);
      end else begin
        o = obs_q[rd];
        rd++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL bad_pid: got %p expected %p", o, e);
        end
      end
    end
    n_cmp++;
    if (rd != obs_q.size()) begin
      n_bad++;
      $display("FAIL bad_pid_extra: got %0d unexpected events expected 0", obs_q.size() - rd);
      rd = obs_q.size();
    end
  endtask
  task automatic test_short_and_abort;
    ev_t e, o;
    send_bits(64'h80, 8, 1'b0);
    send_bits(64'hC3, 8, 1'b0);
    exp_q.push_back(mk(K_D0, 1'b0, 8'd0, 64'd0, cyc + 32'd1));
    send_bits(64'h5555_AAAA_3333_CCCC, 40, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk(K_PERR, 1'b0, 8'd0, 64'd0, cyc + 32'd1));
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (rx.data0 !== 64'hDEAD_BEEF_0BAD_F00D) begin
      n_bad++;
      $display("FAIL short_data0: got %h expected deadbeef0badf00d", rx.data0);
    end
    send_bits(64'h80, 8, 1'b0);
    send_bits(64'hC3, 8, 1'b0);
    exp_q.push_back(mk(K_D0, 1'b0, 8'd0, 64'd0, cyc + 32'd1));
    send_bits(64'hFFFF_0000_FFFF_0000, 20, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (rx.data0 !== 64'h0 || rx.crc_sending !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: got data0=%h crc_sending=%b expected 0 and 0", rx.data0, rx.crc_sending);
    end
    send_handshake(8'hD2, K_ACK, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd >= obs_q.size()) begin
        n_bad++;
        $display("FAIL short_abort: no event, expected %p", e);
      end else begin
        o = obs_q[rd];
        rd++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL short_abort: got %p expected %p", o, e);
        end
      end
    end
    n_cmp++;
    if (rd != obs_q.size()) begin
      n_bad++;
      $display("FAIL short_abort_extra: got %0d unexpected events expected 0", obs_q.size() - rd);
      rd = obs_q.size();
    end
    n_cmp++;
    if (rx.data0 !== 64'h0) begin
      n_bad++;
      $display("FAIL abort_data0: got %h expected 0", rx.data0);
    end
  endtask
  initial begin
    test_reset;
    test_handshakes;
    test_data;
    test_bad_pid;
    test_short_and_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
